// File: rtl/move_scheduler.sv
// move_scheduler: turns debounced key levels into a paced, prioritised,
// single-outstanding command stream for game_control (valid/ready).
module move_scheduler #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3,
  parameter int SD_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       enable,
  input  logic       flush,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_rotate,
  input  logic       key_drop,
  input  logic       ready,
  output logic       cmd_valid,
  output logic [2:0] cmd
);
  localparam int MAX_DA = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int MAXF   = (MAX_DA > SD_FRAMES) ? MAX_DA : SD_FRAMES;
  localparam int CW     = $clog2(MAXF + 1);

  localparam logic [CW-1:0] DAS_C = CW'(DAS_FRAMES);
  localparam logic [CW-1:0] ARR_C = CW'(ARR_FRAMES);
  localparam logic [CW-1:0] SD_C  = CW'(SD_FRAMES);

  // key / pending-flag bit positions
  localparam int K_LEFT = 0, K_RIGHT = 1, K_DOWN = 2, K_ROT = 3, K_DROP = 4;

  localparam logic [2:0] C_NONE = 3'd0, C_LEFT = 3'd1, C_RIGHT = 3'd2,
                         C_ROT  = 3'd3, C_DROP = 3'd4, C_DOWN  = 3'd5;

  typedef enum logic [1:0] {H_NONE, H_LEFT, H_RIGHT} hdir_t;

  logic [4:0]    key_q, key_d, keys, kedge;
  logic [4:0]    pend_q, pend_d, set, clr;
  hdir_t         hdir_q, hdir_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [CW-1:0] scnt_q, scnt_d, scnt_inc;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_q, cmd_d;

  // edge detect, hold/repeat pacing, pending flags and output selection
  always_comb begin
    keys        = {key_drop, key_rotate, key_down, key_right, key_left};
    kedge       = keys & ~key_q;
    key_d       = keys;
    set         = '0;
    clr         = '0;
    hdir_d      = hdir_q;
    rep_d       = rep_q;
    hcnt_d      = hcnt_q;
    scnt_d      = scnt_q;
    hcnt_inc    = hcnt_q + 1'b1;
    scnt_inc    = scnt_q + 1'b1;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;

    // horizontal: edges beat releases, releases beat ticks; left beats right
    if (kedge[K_LEFT]) begin
      hdir_d = H_LEFT; rep_d = 1'b0; hcnt_d = '0; set[K_LEFT] = 1'b1;
    end else if (kedge[K_RIGHT]) begin
      hdir_d = H_RIGHT; rep_d = 1'b0; hcnt_d = '0; set[K_RIGHT] = 1'b1;
    end else if (hdir_q == H_LEFT && !key_left) begin
      hdir_d = key_right ? H_RIGHT : H_NONE; rep_d = 1'b0; hcnt_d = '0;
    end else if (hdir_q == H_RIGHT && !key_right) begin
      hdir_d = key_left ? H_LEFT : H_NONE; rep_d = 1'b0; hcnt_d = '0;
    end else if (tick_game && hdir_q != H_NONE) begin
      if (hcnt_inc == (rep_q ? ARR_C : DAS_C)) begin
        rep_d  = 1'b1;
        hcnt_d = '0;
        if (hdir_q == H_LEFT) set[K_LEFT]  = 1'b1;
        else                  set[K_RIGHT] = 1'b1;
      end else begin
        hcnt_d = hcnt_inc;
      end
    end

    // soft drop pacing
    if (kedge[K_DOWN]) begin
      set[K_DOWN] = 1'b1; scnt_d = '0;
    end else if (!key_down) begin
      scnt_d = '0;
    end else if (tick_game) begin
      if (scnt_inc == SD_C) begin
        set[K_DOWN] = 1'b1; scnt_d = '0;
      end else begin
        scnt_d = scnt_inc;
      end
    end

    set[K_ROT]  = kedge[K_ROT];
    set[K_DROP] = kedge[K_DROP];

    // output register reloads only when empty or being consumed
    if (!cmd_valid_q || ready) begin
      cmd_valid_d = 1'b1;
      if      (pend_q[K_DROP])  begin cmd_d = C_DROP;  clr[K_DROP]  = 1'b1; end
      else if (pend_q[K_ROT])   begin cmd_d = C_ROT;   clr[K_ROT]   = 1'b1; end
      else if (pend_q[K_LEFT])  begin cmd_d = C_LEFT;  clr[K_LEFT]  = 1'b1; end
      else if (pend_q[K_RIGHT]) begin cmd_d = C_RIGHT; clr[K_RIGHT] = 1'b1; end
      else if (pend_q[K_DOWN])  begin cmd_d = C_DOWN;  clr[K_DOWN]  = 1'b1; end
      else begin cmd_valid_d = 1'b0; cmd_d = C_NONE; end
    end

    // a new request survives a same-edge clear of its flag
    pend_d = (pend_q & ~clr) | (enable ? set : 5'b0);

    // flush drops everything but keeps direction tracking the keys
    if (flush) begin
      pend_d      = '0;
      cmd_valid_d = 1'b0;
      cmd_d       = C_NONE;
      hcnt_d      = '0;
      rep_d       = 1'b0;
      scnt_d      = '0;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      pend_q      <= '0;
      hdir_q      <= H_NONE;
      rep_q       <= 1'b0;
      hcnt_q      <= '0;
      scnt_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= C_NONE;
    end else begin
      key_q       <= key_d;
      pend_q      <= pend_d;
      hdir_q      <= hdir_d;
      rep_q       <= rep_d;
      hcnt_q      <= hcnt_d;
      scnt_q      <= scnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
endmodule
